// File: rtl/i2c_deserializer_if.sv
// I2C slave receive front end bus bundle.
// Raw SCL/SDA pin levels enter the deserializer; decoded bus events leave it.
// Handshake semantics: there is no back-pressure. Every *_start/_stop/_valid/
// _xfc_read output is a single-cycle strobe that the consumer must take in the
// cycle it is high; i2c_wfirst is meaningful only while i2c_wdata_valid is high;
// level outputs (addr_match, rw, wdata, ack) hold until the deserializer changes them.
// fsm_state exposes the receive FSM:
//   0 IDLE, 1 ADDR, 2 ADDR_ACK, 3 WRITE, 4 WR_ACK, 5 READ, 6 WAIT_STOP.
interface i2c_deserializer_if;
    logic       i2c_scl;
    logic       i2c_sda_in;
    logic       i2c_start;
    logic       i2c_stop;
    logic       i2c_addr_match;
    logic       i2c_rw;
    logic [7:0] i2c_wdata;
    logic       i2c_wdata_valid;
    logic       i2c_wfirst;
    logic       i2c_ack;
    logic       i2c_xfc_read;
    logic [2:0] fsm_state;

    modport slave (
        input  i2c_scl,
        input  i2c_sda_in,
        output i2c_start,
        output i2c_stop,
        output i2c_addr_match,
        output i2c_rw,
        output i2c_wdata,
        output i2c_wdata_valid,
        output i2c_wfirst,
        output i2c_ack,
        output i2c_xfc_read,
        output fsm_state
    );

    modport master (
        output i2c_scl,
        output i2c_sda_in,
        input  i2c_start,
        input  i2c_stop,
        input  i2c_addr_match,
        input  i2c_rw,
        input  i2c_wdata,
        input  i2c_wdata_valid,
        input  i2c_wfirst,
        input  i2c_ack,
        input  i2c_xfc_read,
        input  fsm_state
    );
endinterface

// File: rtl/i2c_deserializer.sv
// I2C slave receive front end.
// Synchronises SCL/SDA, detects START/STOP, shifts in address and write bytes,
// matches the 7-bit slave address, requests ACKs from the Serializer and asks
// it for read data. All outputs are registered.
module i2c_deserializer #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h48,
    parameter int         SYNC_STAGES = 2
) (
    input logic              Clock,
    input logic              reset,
    i2c_deserializer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WR_ACK    = 3'd4,
        READ      = 3'd5,
        WAIT_STOP = 3'd6
    } state_t;

    state_t state, state_next;

    // Synchroniser chains (bit 0 is the first stage) plus one history flop.
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d;
    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Datapath registers and their next values.
    logic [3:0] bit_cnt, bit_cnt_next;
    logic [7:0] shifter, shifter_next;
    logic [7:0] byte_in;
    logic       addr_match, addr_match_next;
    logic       rw, rw_next;
    logic [7:0] wdata, wdata_next;
    logic       wdata_valid, wdata_valid_next;
    logic       wfirst, wfirst_next;
    logic       ack, ack_next;
    logic       xfc_read, xfc_read_next;
    logic       read_pend, read_pend_next;
    logic       first_byte, first_byte_next;
    logic       start_q, stop_q;

    // Bring the asynchronous pins into the clock domain; idle bus reads high.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.i2c_sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // START/STOP need SCL high in both samples, so they can never coincide
    // with an SCL edge: an SDA change alongside an SCL edge is plain data.
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

    // Byte as it would look after shifting in the current SDA sample.
    assign byte_in = {shifter[6:0], sda_s};

    // FSM state register.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-datapath decode; START/STOP override everything.
    always_comb begin
        state_next       = state;
        bit_cnt_next     = bit_cnt;
        shifter_next     = shifter;
        addr_match_next  = addr_match;
        rw_next          = rw;
        wdata_next       = wdata;
        wdata_valid_next = 1'b0;
        wfirst_next      = 1'b0;
        ack_next         = ack;
        xfc_read_next    = 1'b0;
        read_pend_next   = read_pend;
        first_byte_next  = first_byte;

        if (start_det) begin
            state_next      = ADDR;
            bit_cnt_next    = 4'd0;
            addr_match_next = 1'b0;
            ack_next        = 1'b0;
            read_pend_next  = 1'b0;
            first_byte_next = 1'b0;
        end else if (stop_det) begin
            state_next      = IDLE;
            bit_cnt_next    = 4'd0;
            addr_match_next = 1'b0;
            ack_next        = 1'b0;
            read_pend_next  = 1'b0;
            first_byte_next = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shifter_next = byte_in;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_next = 4'd8;
                            // General call and 10-bit prefixes simply fail this compare.
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                addr_match_next = 1'b1;
                                rw_next         = byte_in[0];
                                first_byte_next = ~byte_in[0];
                                state_next      = ADDR_ACK;
                            end else begin
                                state_next = WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    // First fall opens the ACK slot, second fall closes it.
                    if (scl_fall) begin
                        if (!ack) begin
                            ack_next = 1'b1;
                            if (state == ADDR_ACK && rw) begin
                                xfc_read_next = 1'b1;
                            end
                        end else begin
                            ack_next     = 1'b0;
                            bit_cnt_next = 4'd0;
                            state_next   = (state == ADDR_ACK && rw) ? READ : WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shifter_next = byte_in;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_next     = 4'd8;
                            wdata_next       = byte_in;
                            wdata_valid_next = 1'b1;
                            wfirst_next      = first_byte;
                            first_byte_next  = 1'b0;
                            state_next       = WR_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end
                end
                READ: begin
                    // Slave drives the 8 data bits; only the 9th (master ACK) matters.
                    if (scl_rise) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt_next = 4'd0;
                            if (!sda_s) begin
                                read_pend_next = 1'b1;
                            end else begin
                                state_next = WAIT_STOP;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt + 4'd1;
                        end
                    end else if (scl_fall && read_pend) begin
                        xfc_read_next  = 1'b1;
                        read_pend_next = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= 4'd0;
            shifter     <= 8'h00;
            addr_match  <= 1'b0;
            rw          <= 1'b0;
            wdata       <= 8'h00;
            wdata_valid <= 1'b0;
            wfirst      <= 1'b0;
            ack         <= 1'b0;
            xfc_read    <= 1'b0;
            read_pend   <= 1'b0;
            first_byte  <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_next;
            shifter     <= shifter_next;
            addr_match  <= addr_match_next;
            rw          <= rw_next;
            wdata       <= wdata_next;
            wdata_valid <= wdata_valid_next;
            wfirst      <= wfirst_next;
            ack         <= ack_next;
            xfc_read    <= xfc_read_next;
            read_pend   <= read_pend_next;
            first_byte  <= first_byte_next;
            start_q     <= start_det;
            stop_q      <= stop_det;
        end
    end

    assign bus.i2c_start       = start_q;
    assign bus.i2c_stop        = stop_q;
    assign bus.i2c_addr_match  = addr_match;
    assign bus.i2c_rw          = rw;
    assign bus.i2c_wdata       = wdata;
    assign bus.i2c_wdata_valid = wdata_valid;
    assign bus.i2c_wfirst      = wfirst;
    assign bus.i2c_ack         = ack;
    assign bus.i2c_xfc_read    = xfc_read;
    assign bus.fsm_state       = state;

endmodule

// File: tb/tb_i2c_deserializer.sv
// Bench for i2c_deserializer: an I2C master driver, a protocol-level reference
// model fed from the pin levels, a per-cycle compare, and directed scenarios.
module tb_i2c_deserializer;

    localparam int SYNC = 2;
    localparam int Q    = 4;   // clocks per quarter SCL period

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       match;
        logic       rw;
        logic [7:0] wdata;
        logic       valid;
        logic       wfirst;
        logic       ack;
        logic       xfc;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic reset = 1'b1;
    always #5 Clock = ~Clock;

    i2c_deserializer_if bus();

    i2c_deserializer #(.SLAVE_ADDR(7'h48), .SYNC_STAGES(SYNC)) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 address byte, 2 write data, 3 read data, 4 ignore.
    exp_t m;
    exp_t d [0:SYNC];
    int   phase, nbits, byte_v, ack_falls, nbytes;
    bit   pend;
    logic p_scl, p_sda;

    always @(posedge Clock) begin
        logic cs, cd;
        if (!reset) begin
            m = '0; phase = 0; nbits = 0; byte_v = 0; ack_falls = -1; nbytes = 0; pend = 0;
            p_scl = 1'b1; p_sda = 1'b1;
            for (int i = 0; i <= SYNC; i++) d[i] = '0;
        end else begin
            cs = bus.i2c_scl;
            cd = bus.i2c_sda_in;
            m.start = 0; m.stop = 0; m.valid = 0; m.wfirst = 0; m.xfc = 0;
            if (p_scl && cs && p_sda && !cd) begin
                m.start = 1; phase = 1; nbits = 0; byte_v = 0; ack_falls = -1;
                pend = 0; m.match = 0; m.ack = 0; nbytes = 0;
            end else if (p_scl && cs && !p_sda && cd) begin
                m.stop = 1; phase = 0; nbits = 0; byte_v = 0; ack_falls = -1;
                pend = 0; m.match = 0; m.ack = 0;
            end else if (!p_scl && cs) begin
                if (ack_falls < 0) begin
                    if (phase == 1 || phase == 2) begin
                        byte_v = ((byte_v * 2) + int'(cd)) % 256;
                        nbits++;
                        if (nbits == 8) begin
                            if (phase == 1) begin
                                if (byte_v / 2 == 'h48) begin
                                    m.match = 1; m.rw = (byte_v % 2 == 1);
                                    ack_falls = 0; nbytes = 0;
                                end else begin
                                    phase = 4;
                                end
                            end else begin
                                m.wdata = 8'(byte_v); m.valid = 1;
                                m.wfirst = (nbytes == 0); nbytes++;
                                ack_falls = 0;
                            end
                        end
                    end else if (phase == 3) begin
                        nbits++;
                        if (nbits == 9) begin
                            nbits = 0;
                            if (cd == 1'b0) pend = 1;
                            else phase = 4;
                        end
                    end
                end
            end else if (p_scl && !cs) begin
                if (ack_falls == 0) begin
                    m.ack = 1; ack_falls = 1;
                    if (phase == 1 && m.rw) m.xfc = 1;
                end else if (ack_falls == 1) begin
                    m.ack = 0; ack_falls = -1; nbits = 0; byte_v = 0;
                    if (phase == 1) phase = m.rw ? 3 : 2;
                end else if (phase == 3 && pend) begin
                    m.xfc = 1; pend = 0;
                end
            end
            p_scl = cs;
            p_sda = cd;
            for (int i = SYNC; i > 0; i--) d[i] = d[i-1];
            d[0] = m;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int n_start, n_stop, n_valid, n_wfirst, n_xfc, n_ack_rise;
    logic prev_ack = 1'b0;
    logic [7:0] exp_q[$];   // wdata values seen on valid, in order

    always @(negedge Clock) begin
        exp_t a;
        if (reset) begin
            a = '{bus.i2c_start, bus.i2c_stop, bus.i2c_addr_match, bus.i2c_rw,
                  bus.i2c_wdata, bus.i2c_wdata_valid, bus.i2c_wfirst,
                  bus.i2c_ack, bus.i2c_xfc_read};
            checks++;
            if (a !== d[SYNC]) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got %h expected %h (start,stop,match,rw,wdata,valid,wfirst,ack,xfc)",
                         $time, a, d[SYNC]);
            end
            n_start  += int'(bus.i2c_start);
            n_stop   += int'(bus.i2c_stop);
            n_valid  += int'(bus.i2c_wdata_valid);
            n_wfirst += int'(bus.i2c_wdata_valid & bus.i2c_wfirst);
            n_xfc    += int'(bus.i2c_xfc_read);
            if (bus.i2c_ack && !prev_ack) n_ack_rise++;
            if (bus.i2c_wdata_valid) exp_q.push_back(bus.i2c_wdata);
            prev_ack = bus.i2c_ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_start = 0; n_stop = 0; n_valid = 0; n_wfirst = 0; n_xfc = 0; n_ack_rise = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic bus_start();
        bus.i2c_sda_in = 1'b1; wait_clks(Q);
        bus.i2c_scl    = 1'b1; wait_clks(Q);
        bus.i2c_sda_in = 1'b0; wait_clks(Q);
        bus.i2c_scl    = 1'b0; wait_clks(Q);
    endtask

    task automatic bus_stop();
        bus.i2c_sda_in = 1'b0; wait_clks(Q);
        bus.i2c_scl    = 1'b1; wait_clks(Q);
        bus.i2c_sda_in = 1'b1; wait_clks(4 * Q);
    endtask

    task automatic send_bit(input logic b);
        bus.i2c_sda_in = b; wait_clks(Q);
        bus.i2c_scl    = 1'b1; wait_clks(2 * Q);
        bus.i2c_scl    = 1'b0; wait_clks(Q);
    endtask

    // Master writes a byte; SDA released during the ACK slot.
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        send_bit(1'b1);
    endtask

    // Master reads a byte (data level arbitrary) then ACKs (1) or NACKs (0).
    task automatic read_byte(input bit master_ack);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        send_bit(master_ack ? 1'b0 : 1'b1);
    endtask

    task automatic reset_checks(input string tag);
        lit({tag, "_start"},  int'(bus.i2c_start), 0);
        lit({tag, "_stop"},   int'(bus.i2c_stop), 0);
        lit({tag, "_match"},  int'(bus.i2c_addr_match), 0);
        lit({tag, "_rw"},     int'(bus.i2c_rw), 0);
        lit({tag, "_wdata"},  int'(bus.i2c_wdata), 0);
        lit({tag, "_valid"},  int'(bus.i2c_wdata_valid), 0);
        lit({tag, "_ack"},    int'(bus.i2c_ack), 0);
        lit({tag, "_xfc"},    int'(bus.i2c_xfc_read), 0);
        lit({tag, "_state"},  int'(bus.fsm_state), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed scenarios ----------------
    initial begin
        bus.i2c_scl    = 1'b1;
        bus.i2c_sda_in = 1'b1;
        clear_counts();
        #1 reset = 1'b0;
        wait_clks(3);
        reset_checks("por");
        @(negedge Clock); #2 reset = 1'b1;
        wait_clks(5);

        // 1. write two bytes to 0x48
        clear_counts();
        bus_start(); send_byte(8'h90); send_byte(8'h05); send_byte(8'hA7); bus_stop();
        lit("t1_ack_slots", n_ack_rise, 3);
        lit("t1_valid", n_valid, 2);
        lit("t1_wfirst", n_wfirst, 1);
        lit("t1_nbytes", exp_q.size(), 2);
        if (exp_q.size() == 2) begin
            lit("t1_byte0", int'(exp_q[0]), 'h05);
            lit("t1_byte1", int'(exp_q[1]), 'hA7);
        end
        lit("t1_wdata", int'(bus.i2c_wdata), 'hA7);
        lit("t1_stop", n_stop, 1);
        lit("t1_start", n_start, 1);
        lit("t1_match_after_stop", int'(bus.i2c_addr_match), 0);

        // 2. address mismatch
        clear_counts();
        bus_start(); send_byte(8'h92); send_byte(8'h11);
        lit("t2_ack_slots", n_ack_rise, 0);
        lit("t2_valid", n_valid, 0);
        lit("t2_wait_stop", int'(bus.fsm_state), 6);
        bus_stop();
        lit("t2_idle", int'(bus.fsm_state), 0);

        // 3. read burst: ACK, ACK, NACK
        clear_counts();
        bus_start(); send_byte(8'h91);
        read_byte(1'b1); read_byte(1'b1); read_byte(1'b0);
        bus_stop();
        lit("t3_xfc", n_xfc, 3);
        lit("t3_rw", int'(bus.i2c_rw), 1);
        lit("t3_valid", n_valid, 0);
        lit("t3_ack_slots", n_ack_rise, 1);

        // 4. register write then repeated START into a read
        clear_counts();
        bus_start(); send_byte(8'h90); send_byte(8'h10);
        lit("t4_rw_write", int'(bus.i2c_rw), 0);
        bus_start(); send_byte(8'h91); read_byte(1'b0); bus_stop();
        lit("t4_start", n_start, 2);
        lit("t4_rw_read", int'(bus.i2c_rw), 1);
        lit("t4_xfc", n_xfc, 1);
        lit("t4_valid", n_valid, 1);
        lit("t4_wfirst", n_wfirst, 1);
        lit("t4_wdata", int'(bus.i2c_wdata), 'h10);

        // 5a. STOP after 4 data bits
        clear_counts();
        bus_start(); send_byte(8'h90);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        lit("t5_partial_valid", n_valid, 0);
        lit("t5_partial_stop", n_stop, 1);
        lit("t5_partial_idle", int'(bus.fsm_state), 0);

        // 5b. reset mid-byte, then a normal transfer
        bus_start(); send_byte(8'h90);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        @(negedge Clock); #2 reset = 1'b0;
        #1 reset_checks("midrst");
        wait_clks(4);
        @(negedge Clock); #2 reset = 1'b1;
        wait_clks(6);
        clear_counts();
        bus_start(); send_byte(8'h90); send_byte(8'h3C); bus_stop();
        lit("t5_start", n_start, 1);
        lit("t5_valid", n_valid, 1);
        lit("t5_ack_slots", n_ack_rise, 2);
        lit("t5_wdata", int'(bus.i2c_wdata), 'h3C);

        wait_clks(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
